// File: rtl/ibex_rf_wb_pkg.sv
// Shared types and helpers for the Ibex register-file write-back controller.
package ibex_rf_wb_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned MAX_WORDS      = 32;
  localparam int unsigned DATA_WIDTH     = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [MAX_WORDS-1:0]      reg_mask_t;

  typedef struct packed {
    reg_addr_t             addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_LSU,
    WB_SRC_SKID,
    WB_SRC_EX
  } wb_src_e;

  function automatic int unsigned addr_width(bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

  function automatic int unsigned num_words(bit rv32e);
    return 32'd1 << addr_width(rv32e);
  endfunction

  // One-hot of a writable register; x0 and out-of-range addresses give an empty mask.
  function automatic reg_mask_t addr_onehot(reg_addr_t addr, int unsigned words);
    reg_mask_t mask;
    mask = '0;
    if (addr != '0 && 32'(addr) < words) mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/ibex_rf_load_fifo.sv
// In-order FIFO of destination addresses for outstanding loads.
module ibex_rf_load_fifo
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  reg_addr_t wdata,
  output reg_addr_t rdata,
  output logic      empty,
  output logic      full
);

  localparam int unsigned PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CNT_W = $clog2(Depth + 1);

  reg_addr_t        mem [Depth];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(Depth));
  assign rdata = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ibex_rf_write_ctrl.sv
// Merges ALU results and in-order load responses onto the RF write port with a RAW scoreboard.
// Define IBEX_RF_WB_FWD_EN to forward the write-cycle data and drop the hazard in that cycle.
module ibex_rf_write_ctrl
  import ibex_rf_wb_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxLoads  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_req_i,
  output logic                 lsu_req_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 load_err_o
`ifdef IBEX_RF_WB_FWD_EN
  ,
  output logic [DataWidth-1:0] fwd_a_o,
  output logic [DataWidth-1:0] fwd_b_o
`endif
);

  localparam int unsigned NumWords = num_words(RV32E);

  if (DataWidth != DATA_WIDTH || MaxLoads < 1) begin : g_param_check
    $error("ibex_rf_write_ctrl: unsupported DataWidth or MaxLoads");
  end

  logic      ex_accept, lsu_accept, lsu_pop;
  logic      fifo_empty, fifo_full;
  reg_addr_t load_addr;
  logic      skid_valid_q, skid_valid_d, skid_load;
  wb_entry_t skid_q, wb_entry;
  wb_src_e   wb_src;
  logic      wb_we;
  reg_mask_t pending_q, pending_d;
  reg_mask_t ex_mask, ld_mask, set_mask, write_mask, err_mask, hazard_vec;
  logic      illegal_set;

  assign ex_ready_o      = !skid_valid_q;
  assign lsu_req_ready_o = !fifo_full;
  assign ex_accept       = ex_valid_i && ex_ready_o;
  assign lsu_accept      = lsu_req_i && lsu_req_ready_o;
  // A response with no load outstanding (e.g. issued before a reset) is dropped.
  assign lsu_pop         = lsu_rvalid_i && !fifo_empty;

  ibex_rf_load_fifo #(
    .Depth (MaxLoads)
  ) u_load_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (lsu_accept),
    .pop   (lsu_pop),
    .wdata (lsu_waddr_i),
    .rdata (load_addr),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Write-port arbitration: load response, then skid, then fresh ALU result.
  always_comb begin
    wb_src   = WB_SRC_NONE;
    wb_entry = '0;
    if (lsu_pop) begin
      wb_src   = WB_SRC_LSU;
      wb_entry = '{addr: load_addr, data: lsu_rdata_i};
    end else if (skid_valid_q) begin
      wb_src   = WB_SRC_SKID;
      wb_entry = skid_q;
    end else if (ex_accept) begin
      wb_src   = WB_SRC_EX;
      wb_entry = '{addr: ex_waddr_i, data: ex_wdata_i};
    end
  end

  assign wb_we = (wb_src != WB_SRC_NONE) && !(wb_src == WB_SRC_LSU && lsu_err_i)
                 && (addr_onehot(wb_entry.addr, NumWords) != '0);

  assign skid_load    = ex_accept && lsu_pop && (addr_onehot(ex_waddr_i, NumWords) != '0);
  assign skid_valid_d = skid_valid_q ? lsu_pop : skid_load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      if (skid_load) skid_q <= '{addr: ex_waddr_i, data: ex_wdata_i};
    end
  end

  assign ex_mask    = ex_accept  ? addr_onehot(ex_waddr_i, NumWords)  : '0;
  assign ld_mask    = lsu_accept ? addr_onehot(lsu_waddr_i, NumWords) : '0;
  assign set_mask   = ex_mask | ld_mask;
  assign write_mask = rf_we_o ? addr_onehot(rf_waddr_o, NumWords) : '0;
  assign err_mask   = (lsu_pop && lsu_err_i) ? addr_onehot(load_addr, NumWords) : '0;
  assign pending_d  = (pending_q & ~(write_mask | err_mask)) | set_mask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      load_err_o <= 1'b0;
      pending_q  <= '0;
    end else begin
      rf_we_o    <= wb_we;
      load_err_o <= lsu_pop && lsu_err_i;
      pending_q  <= pending_d;
      if (wb_we) begin
        rf_waddr_o <= wb_entry.addr;
        rf_wdata_o <= wb_entry.data;
      end
    end
  end

`ifdef IBEX_RF_WB_FWD_EN
  assign hazard_vec = set_mask | (pending_q & ~write_mask);
  assign fwd_a_o    = (rf_we_o && rf_waddr_o == raddr_a_i) ? rf_wdata_o : '0;
  assign fwd_b_o    = (rf_we_o && rf_waddr_o == raddr_b_i) ? rf_wdata_o : '0;
`else
  assign hazard_vec = set_mask | pending_q;
`endif

  assign hazard_a_o = hazard_vec[raddr_a_i];
  assign hazard_b_o = hazard_vec[raddr_b_i];

  // A register may only be re-reserved in the cycle its previous write retires.
  assign illegal_set = ((ex_mask & ld_mask) != '0) || ((set_mask & pending_q & ~write_mask) != '0);

  a_no_double_pending: assert property (@(posedge clk_i) disable iff (!rst_ni) !illegal_set);

endmodule

// File: tb/tb_ibex_rf_write_ctrl.sv
// Directed vector bench for ibex_rf_write_ctrl (IBEX_RF_WB_FWD_EN adds the forwarding checks).
module tb_ibex_rf_write_ctrl;

`ifdef IBEX_RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        lsu_req, lsu_req_ready;
  logic [4:0]  lsu_waddr;
  logic        lsu_rvalid, lsu_err;
  logic [31:0] lsu_rdata;
  logic [4:0]  raddr_a, raddr_b;
  logic        hazard_a, hazard_b;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_we, load_err;
`ifdef IBEX_RF_WB_FWD_EN
  logic [31:0] fwd_a, fwd_b;
`endif

  always #5 clk = ~clk;

  ibex_rf_write_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ex_valid_i      (ex_valid),
    .ex_ready_o      (ex_ready),
    .ex_waddr_i      (ex_waddr),
    .ex_wdata_i      (ex_wdata),
    .lsu_req_i       (lsu_req),
    .lsu_req_ready_o (lsu_req_ready),
    .lsu_waddr_i     (lsu_waddr),
    .lsu_rvalid_i    (lsu_rvalid),
    .lsu_rdata_i     (lsu_rdata),
    .lsu_err_i       (lsu_err),
    .raddr_a_i       (raddr_a),
    .raddr_b_i       (raddr_b),
    .hazard_a_o      (hazard_a),
    .hazard_b_o      (hazard_b),
    .rf_waddr_o      (rf_waddr),
    .rf_wdata_o      (rf_wdata),
    .rf_we_o         (rf_we),
    .load_err_o      (load_err)
`ifdef IBEX_RF_WB_FWD_EN
    ,
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b)
`endif
  );

  typedef struct {
    string       name;
    logic        exv;
    logic [4:0]  exa;
    logic [31:0] exd;
    logic        rq;
    logic [4:0]  rqa;
    logic        rv;
    logic [31:0] rd;
    logic        er;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        exr;
    logic        rqr;
    logic        ha;
    logic        hb;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        le;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(string n, int exv, int exa, int exd, int rq, int rqa,
                              int rv, int rd, int er, int ra, int rb,
                              int exr, int rqr, int ha, int hb, int we, int wa, int wd, int le);
    vec_t v;
    v.name = n;   v.exv = 1'(exv); v.exa = 5'(exa); v.exd = 32'(exd);
    v.rq = 1'(rq); v.rqa = 5'(rqa); v.rv = 1'(rv);  v.rd = 32'(rd); v.er = 1'(er);
    v.ra = 5'(ra); v.rb = 5'(rb);
    v.exr = 1'(exr); v.rqr = 1'(rqr); v.ha = 1'(ha); v.hb = 1'(hb);
    v.we = 1'(we); v.wa = 5'(wa); v.wd = 32'(wd); v.le = 1'(le);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_valid = v.exv; ex_waddr = v.exa; ex_wdata = v.exd;
    lsu_req = v.rq; lsu_waddr = v.rqa;
    lsu_rvalid = v.rv; lsu_rdata = v.rd; lsu_err = v.er;
    raddr_a = v.ra; raddr_b = v.rb;
  endtask

  task automatic idle(input int ra, input int rb);
    drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, ra, rb, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic hit_a, hit_b;
    rst_n = 1'b0;
    idle(0, 0);

    // Reset state
    #12;
    check("rst.ex_ready", 32'(ex_ready), 32'd1);
    check("rst.req_ready", 32'(lsu_req_ready), 32'd1);
    check("rst.rf_we", 32'(rf_we), 32'd0);
    check("rst.rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst.rf_wdata", rf_wdata, 32'd0);
    check("rst.load_err", 32'(load_err), 32'd0);
    check("rst.haz_a", 32'(hazard_a), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    //                  name         exv exa exd          rq rqa rv rd       er ra  rb   exr rqr ha hb we wa  wd           le
    vecs.push_back(mk("t1_ex",      1,  5,  'hDEADBEEF, 0, 0,  0, 0,      0, 5,  0,   1,  1,  1, 0, 0, 0,  0,           0));
    vecs.push_back(mk("t1_wr",      0,  0,  0,          0, 0,  0, 0,      0, 5,  0,   1,  1,  1, 0, 1, 5,  'hDEADBEEF, 0));
    vecs.push_back(mk("t1_clr",     0,  0,  0,          0, 0,  0, 0,      0, 5,  0,   1,  1,  0, 0, 0, 0,  0,           0));
    vecs.push_back(mk("t2_ld",      0,  0,  0,          1, 7,  0, 0,      0, 7,  8,   1,  1,  1, 0, 0, 0,  0,           0));
    vecs.push_back(mk("t2_mix",     1,  8,  'h22,       0, 0,  1, 'h11,   0, 7,  8,   1,  1,  1, 1, 0, 0,  0,           0));
    vecs.push_back(mk("t2_x7",      0,  0,  0,          0, 0,  0, 0,      0, 7,  8,   0,  1,  1, 1, 1, 7,  'h11,        0));
    vecs.push_back(mk("t2_x8",      0,  0,  0,          0, 0,  0, 0,      0, 7,  8,   1,  1,  0, 1, 1, 8,  'h22,        0));
    vecs.push_back(mk("t2_clr",     0,  0,  0,          0, 0,  0, 0,      0, 7,  8,   1,  1,  0, 0, 0, 0,  0,           0));
    vecs.push_back(mk("t3_ld3",     0,  0,  0,          1, 3,  0, 0,      0, 3,  4,   1,  1,  1, 0, 0, 0,  0,           0));
    vecs.push_back(mk("t3_ld4",     0,  0,  0,          1, 4,  0, 0,      0, 3,  4,   1,  1,  1, 1, 0, 0,  0,           0));
    vecs.push_back(mk("t3_full",    0,  0,  0,          1, 9,  0, 0,      0, 9,  4,   1,  0,  0, 1, 0, 0,  0,           0));
    vecs.push_back(mk("t3_rsp3",    0,  0,  0,          0, 0,  1, 'hA,    0, 3,  4,   1,  0,  1, 1, 0, 0,  0,           0));
    vecs.push_back(mk("t3_rsp4",    0,  0,  0,          0, 0,  1, 'hB,    0, 3,  4,   1,  1,  1, 1, 1, 3,  'hA,         0));
    vecs.push_back(mk("t3_w4",      0,  0,  0,          0, 0,  0, 0,      0, 3,  4,   1,  1,  0, 1, 1, 4,  'hB,         0));
    vecs.push_back(mk("t3_done",    0,  0,  0,          0, 0,  0, 0,      0, 9,  4,   1,  1,  0, 0, 0, 0,  0,           0));
    vecs.push_back(mk("t4_ld",      0,  0,  0,          1, 3,  0, 0,      0, 3,  6,   1,  1,  1, 0, 0, 0,  0,           0));
    vecs.push_back(mk("t4_err",     0,  0,  0,          1, 6,  1, 'h123,  1, 3,  6,   1,  1,  1, 1, 0, 0,  0,           0));
    vecs.push_back(mk("t4_pulse",   0,  0,  0,          0, 0,  0, 0,      0, 3,  6,   1,  1,  0, 1, 0, 0,  0,           1));
    vecs.push_back(mk("t4_rsp6",    0,  0,  0,          0, 0,  1, 'h66,   0, 3,  6,   1,  1,  0, 1, 0, 0,  0,           0));
    vecs.push_back(mk("t4_w6",      0,  0,  0,          0, 0,  0, 0,      0, 3,  6,   1,  1,  0, 1, 1, 6,  'h66,        0));
    vecs.push_back(mk("t4_clr",     0,  0,  0,          0, 0,  0, 0,      0, 3,  6,   1,  1,  0, 0, 0, 0,  0,           0));
    vecs.push_back(mk("t5_x0",      1,  0,  'hFF,       0, 0,  0, 0,      0, 0,  0,   1,  1,  0, 0, 0, 0,  0,           0));
    vecs.push_back(mk("t5_chk",     0,  0,  0,          0, 0,  0, 0,      0, 0,  0,   1,  1,  0, 0, 0, 0,  0,           0));
    vecs.push_back(mk("spur_rv",    0,  0,  0,          0, 0,  1, 'h77,   0, 0,  0,   1,  1,  0, 0, 0, 0,  0,           0));
    vecs.push_back(mk("spur_chk",   0,  0,  0,          0, 0,  0, 0,      0, 0,  0,   1,  1,  0, 0, 0, 0,  0,           0));
    vecs.push_back(mk("sk_ld10",    0,  0,  0,          1, 10, 0, 0,      0, 10, 12,  1,  1,  1, 0, 0, 0,  0,           0));
    vecs.push_back(mk("sk_ld11",    0,  0,  0,          1, 11, 0, 0,      0, 11, 12,  1,  1,  1, 0, 0, 0,  0,           0));
    vecs.push_back(mk("sk_mix",     1,  12, 'h1212,     0, 0,  1, 'h1010, 0, 10, 12,  1,  0,  1, 1, 0, 0,  0,           0));
    vecs.push_back(mk("sk_hold",    1,  13, 'h1313,     0, 0,  1, 'h1111, 0, 13, 12,  0,  1,  0, 1, 1, 10, 'h1010,      0));
    vecs.push_back(mk("sk_drain",   0,  0,  0,          0, 0,  0, 0,      0, 11, 12,  0,  1,  1, 1, 1, 11, 'h1111,      0));
    vecs.push_back(mk("sk_w12",     0,  0,  0,          0, 0,  0, 0,      0, 11, 12,  1,  1,  0, 1, 1, 12, 'h1212,      0));
    vecs.push_back(mk("sk_clr",     0,  0,  0,          0, 0,  0, 0,      0, 13, 12,  1,  1,  0, 0, 0, 0,  0,           0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #4;
      hit_a = FWD && vecs[i].we && (vecs[i].wa == vecs[i].ra);
      hit_b = FWD && vecs[i].we && (vecs[i].wa == vecs[i].rb);
      check({vecs[i].name, ".ex_ready"}, 32'(ex_ready), 32'(vecs[i].exr));
      check({vecs[i].name, ".req_ready"}, 32'(lsu_req_ready), 32'(vecs[i].rqr));
      check({vecs[i].name, ".haz_a"}, 32'(hazard_a), 32'(vecs[i].ha && !hit_a));
      check({vecs[i].name, ".haz_b"}, 32'(hazard_b), 32'(vecs[i].hb && !hit_b));
      check({vecs[i].name, ".rf_we"}, 32'(rf_we), 32'(vecs[i].we));
      check({vecs[i].name, ".load_err"}, 32'(load_err), 32'(vecs[i].le));
      if (vecs[i].we) begin
        check({vecs[i].name, ".rf_waddr"}, 32'(rf_waddr), 32'(vecs[i].wa));
        check({vecs[i].name, ".rf_wdata"}, rf_wdata, vecs[i].wd);
      end
`ifdef IBEX_RF_WB_FWD_EN
      check({vecs[i].name, ".fwd_a"}, fwd_a, hit_a ? vecs[i].wd : 32'd0);
      check({vecs[i].name, ".fwd_b"}, fwd_b, hit_b ? vecs[i].wd : 32'd0);
`endif
      next_cycle();
    end

    // Reset with two loads in flight, then stale responses
    drive(mk("t6_ld3", 0, 0, 0, 1, 3, 0, 0, 0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    drive(mk("t6_ld4", 0, 0, 0, 1, 4, 0, 0, 0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    idle(3, 4);
    #4;
    check("t6_pre.haz_a", 32'(hazard_a), 32'd1);
    check("t6_pre.haz_b", 32'(hazard_b), 32'd1);
    check("t6_pre.req_ready", 32'(lsu_req_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst.haz_a", 32'(hazard_a), 32'd0);
    check("t6_rst.haz_b", 32'(hazard_b), 32'd0);
    check("t6_rst.req_ready", 32'(lsu_req_ready), 32'd1);
    check("t6_rst.rf_we", 32'(rf_we), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(mk("t6_rv_a", 0, 0, 0, 0, 0, 1, 'hA, 0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    drive(mk("t6_rv_b", 0, 0, 0, 0, 0, 1, 'hB, 0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    #4;
    check("t6_post1.rf_we", 32'(rf_we), 32'd0);
    next_cycle();
    idle(3, 4);
    #4;
    check("t6_post2.rf_we", 32'(rf_we), 32'd0);
    check("t6_post2.haz_a", 32'(hazard_a), 32'd0);
    check("t6_post2.haz_b", 32'(hazard_b), 32'd0);
    check("t6_post2.req_ready", 32'(lsu_req_ready), 32'd1);
    next_cycle();

`ifdef IBEX_RF_WB_FWD_EN
    drive(mk("fwd_ex", 1, 9, 'h55, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0));
    #4;
    check("fwd_ex.haz_b", 32'(hazard_b), 32'd1);
    next_cycle();
    idle(0, 9);
    #4;
    check("fwd_wr.rf_we", 32'(rf_we), 32'd1);
    check("fwd_wr.haz_b", 32'(hazard_b), 32'd0);
    check("fwd_wr.fwd_b", fwd_b, 32'h55);
    check("fwd_wr.fwd_a", fwd_a, 32'd0);
    next_cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
